// File: rtl/dm_access_unit_if.sv
// Pipeline-to-data-memory access bundle: MEM-stage request/response plus the
// word-wide data memory port. The unit takes the slave side.
interface dm_access_unit_if #(
  parameter int DM_ADDR_W = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_sign;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 dm_read;
  logic                 dm_write;
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [31:0]          dm_wdata;
  logic [31:0]          dm_rdata;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           dm_read, dm_write, dm_addr, dm_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           dm_read, dm_write, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide data memory; sub-word stores use RMW.
// Latency: err 1, word store 2, load 3, sub-word store 4 cycles; one access in flight, ready only in IDLE.
module dm_access_unit #(
  parameter int DM_ADDR_W = 10,
  parameter int DM_DEPTH  = 1024
) (
  input logic           clk,
  input logic           rst,
  dm_access_unit_if.slave bus
);

  localparam logic [31:0] DEPTH_LIM = 32'(DM_DEPTH);

  typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, RESP} state_t;

  state_t               state;
  logic                 we_q;
  logic                 sign_q;
  logic [1:0]           size_q;
  logic [DM_ADDR_W+1:0] addr_q;
  logic [15:0]          wdata_q;
  logic                 req_err;
  logic                 req_rmw;

  // Select the addressed lane(s), right-align and extend.
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] ofs,
                                               input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ofs, 3'b000} +: 8];
    h = w[{ofs[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   lane_extract = {{24{sg & b[7]}}, b};
      2'b01:   lane_extract = {{16{sg & h[15]}}, h};
      default: lane_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] ofs,
                                             input logic half, input logic [15:0] d);
    logic [31:0] m;
    logic [31:0] v;
    if (half) begin
      m = 32'h0000_FFFF << {ofs[1], 4'b0000};
      v = {16'h0000, d} << {ofs[1], 4'b0000};
    end else begin
      m = 32'h0000_00FF << {ofs, 3'b000};
      v = {24'h00_0000, d[7:0]} << {ofs, 3'b000};
    end
    lane_merge = (w & ~m) | v;
  endfunction

  // Rejection is decided on the live request so the error path never touches memory.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_LIM) begin
      req_err = 1'b1;
    end
    req_rmw = bus.req_we && (bus.req_size != 2'b10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      sign_q        <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.dm_read   <= 1'b0;
      bus.dm_write  <= 1'b0;
      bus.dm_addr   <= '0;
      bus.dm_wdata  <= '0;
    end else begin
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.dm_read   <= 1'b0;
      bus.dm_write  <= 1'b0;
      bus.dm_addr   <= '0;
      bus.dm_wdata  <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[DM_ADDR_W+1:0];
            wdata_q <= bus.req_wdata[15:0];
            if (req_err) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else if (!bus.req_we || req_rmw) begin
              state       <= READ;
              bus.dm_read <= 1'b1;
              bus.dm_addr <= bus.req_addr[DM_ADDR_W+1:2];
            end else begin
              state        <= WRITE;
              bus.dm_write <= 1'b1;
              bus.dm_addr  <= bus.req_addr[DM_ADDR_W+1:2];
              bus.dm_wdata <= bus.req_wdata;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        READ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          // Memory data is valid now; either merge for the write-back or return it.
          if (we_q) begin
            state        <= WRITE;
            bus.dm_write <= 1'b1;
            bus.dm_addr  <= addr_q[DM_ADDR_W+1:2];
            bus.dm_wdata <= lane_merge(bus.dm_rdata, addr_q[1:0], size_q[0], wdata_q);
          end else begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= lane_extract(bus.dm_rdata, addr_q[1:0], size_q, sign_q);
          end
        end
        WRITE: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboarded random test of dm_access_unit against a byte-lane memory model.
module tb_dm_access_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1000;

  typedef struct {
    logic              err;
    logic [31:0]       rdata;
    int                lat;
    int                nrd;
    int                nwr;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wword;
    int                acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  logic [31:0] mem[2**ADDR_W];
  logic [31:0] shadow[2**ADDR_W];

  dm_access_unit_if #(.DM_ADDR_W(ADDR_W)) bus();

  dm_access_unit #(.DM_ADDR_W(ADDR_W), .DM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous data memory: read data appears the cycle after dm_read.
  always @(posedge clk) begin
    if (bus.dm_write) mem[bus.dm_addr] <= bus.dm_wdata;
    if (bus.dm_read)  bus.dm_rdata <= mem[bus.dm_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: byte-lane arithmetic on a shadow memory.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    logic [31:0] old, lmask, fmask, v;
    int nb, lane, idx;
    e = '{err: 1'b0, rdata: 32'h0, lat: 0, nrd: 0, nwr: 0, idx: '0, wword: 32'h0, acc: 0};
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    e.err = (sz == 2'd3) || ((a % nb) != 0) || ((a >> 2) >= DEPTH);
    if (e.err) begin
      e.lat = 1;
      return;
    end
    idx   = int'(a >> 2);
    e.idx = idx[ADDR_W-1:0];
    old   = shadow[idx];
    lmask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    if (!we) begin
      v = (old >> (8 * lane)) & lmask;
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~lmask;
      e.rdata = v;
      e.lat   = 3;
      e.nrd   = 1;
    end else begin
      fmask       = lmask << (8 * lane);
      e.wword     = (old & ~fmask) | ((wd << (8 * lane)) & fmask);
      shadow[idx] = e.wword;
      e.nwr       = 1;
      e.nrd       = (nb < 4) ? 1 : 0;
      e.lat       = (nb < 4) ? 4 : 2;
    end
  endtask

  // Called on a negedge; returns on the negedge after acceptance with req_valid still high.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic rdy;
    bit   ok = 1'b0;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_sign  = sg;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        model(we, sz, sg, a, wd, e);
        e.acc = cyc;
        q.push_back(e);
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles (addr %h)", a);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("strobe_overlap", {31'h0, bus.dm_read & bus.dm_write}, 32'h0);
      if (!bus.dm_read && !bus.dm_write) begin
        chk("idle_dm_addr", 32'(bus.dm_addr), 32'h0);
        chk("idle_dm_wdata", bus.dm_wdata, 32'h0);
      end
      if (q.size() > 0) chk("ready_busy", {31'h0, bus.req_ready}, 32'h0);
      if (bus.dm_read || bus.dm_write) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got rd=%b wr=%b expected none", bus.dm_read, bus.dm_write);
        end else begin
          chk("dm_addr", 32'(bus.dm_addr), 32'(q[0].idx));
          if (bus.dm_write) chk("dm_wdata", bus.dm_wdata, q[0].wword);
        end
        if (bus.dm_read)  rd_cnt++;
        if (bus.dm_write) wr_cnt++;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid expected none");
        end else begin
          e = q.pop_front();
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("dm_read_count", 32'(rd_cnt), 32'(e.nrd));
          chk("dm_write_count", 32'(wr_cnt), 32'(e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] v, saved;
    int bad, r, idx;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      v = $urandom;
      mem[i]    <= v;
      shadow[i]  = v;
    end
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_dm_read", {31'h0, bus.dm_read}, 32'h0);
    chk("rst_dm_write", {31'h0, bus.dm_write}, 32'h0);
    chk("rst_dm_addr", 32'(bus.dm_addr), 32'h0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases, issued back-to-back.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_0055);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80F0_017F);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_A5C3);
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'(4 * DEPTH - 1), 32'h0000_00AA);
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during RWAIT of a byte store: aborted, memory untouched.
    saved = shadow[5];
    issue(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_0011);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    shadow[5] = saved;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (5) @(negedge clk);
    chk("abort_no_strobe", 32'(rd_cnt + wr_cnt), 32'h0);

    // Reset wins over a simultaneous request.
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    chk("rstprio_req_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (5) @(negedge clk);
    chk("rstprio_no_strobe", 32'(rd_cnt + wr_cnt), 32'h0);

    // Random traffic concentrated on a few words and the top-of-memory boundary.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       idx = r;
      else if (r == 8) idx = DEPTH - 1;
      else             idx = DEPTH + int'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'(idx * 4) + 32'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'h0);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== shadow[i]) bad++;
    end
    chk("mem_final_mismatch_words", 32'(bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter DM_ADDR_W, 10, word-address width of the data memory port.
REQ-002 Parameter DM_DEPTH, 1024, number of 32-bit words implemented in the data memory.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  pipeline MEM stage presents an access.
REQ-006 req_ready  output  1  unit can accept an access this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-009 req_sign  input  1  1 = sign-extend sub-word load, 0 = zero-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned for sub-word stores.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  access rejected (misaligned, reserved size, out of range).
REQ-015 dm_read  output  1  data memory read strobe.
REQ-016 dm_write  output  1  data memory write strobe.
REQ-017 dm_addr  output  DM_ADDR_W  word index = req_addr[DM_ADDR_W+1:2].
REQ-018 dm_wdata  output  32  full word to write.
REQ-019 dm_rdata  input  32  memory read data, valid the cycle after dm_read is high.

Function
REQ-020 FSM states SHALL be IDLE, READ, RWAIT, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept occurs on a clock edge with req_valid and req_ready both 1; the unit SHALL latch req_we, req_size, req_sign, req_addr, req_wdata at that edge.
REQ-022 Error check at accept: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or word index >= DM_DEPTH -> go to RESP with rsp_err=1, no DM strobe issued.
REQ-023 Valid load: IDLE -> READ (dm_read=1) -> RWAIT (capture dm_rdata) -> RESP; rsp_valid at accept edge +3 cycles.
REQ-024 Valid word store: IDLE -> WRITE (dm_write=1, dm_wdata=req_wdata) -> RESP; rsp_valid at accept +2.
REQ-025 Valid byte/halfword store: IDLE -> READ -> RWAIT -> WRITE -> RESP (read-modify-write); rsp_valid at accept +4.
REQ-026 Byte lanes little-endian: byte k = bits 8k+7:8k for addr[1:0]=k; halfword at addr[1] occupies bits 16*addr[1]+15:16*addr[1].
REQ-027 RMW merge SHALL replace only the addressed lane(s) of the captured word with req_wdata[7:0] or [15:0]; other lanes unchanged.
REQ-028 Load extraction SHALL select addressed lane(s), shift to bit 0, and extend per req_sign to 32 bits.
REQ-029 All outputs SHALL be registered; dm_read, dm_write, rsp_valid SHALL each be 1 for exactly one cycle per transaction and 0 in all other states.
REQ-030 dm_read and dm_write SHALL never be 1 in the same cycle.
REQ-031 dm_addr and dm_wdata SHALL be 0 whenever neither strobe is high.
REQ-032 RESP returns to IDLE unconditionally; a new request is accepted no earlier than the cycle after RESP (no response backpressure).
REQ-033 req_valid while req_ready=0 SHALL be ignored; the pipeline holds its request until accepted.

Reset
REQ-034 On a clock edge with rst=1 the FSM SHALL enter IDLE and the cycle after, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_read=0, dm_write=0, dm_addr=0, dm_wdata=0.
REQ-035 Reset in any state SHALL abort the transaction with no response; a strobe already driven in the reset cycle is not retracted, no further strobe is issued.
REQ-036 rst has priority over an accept in the same cycle; the request is not taken.

Verification
REQ-037 Word store addr 0x10 data 0xDEADBEEF, then word load addr 0x10 -> dm_write at accept+1 with dm_addr=4; load rsp_rdata=0xDEADBEEF, rsp_valid at accept+3.
REQ-038 Memory word 4 = 0xDEADBEEF; byte store 0x55 at addr 0x12 -> dm_read then dm_write with dm_wdata=0xDE55BEEF, rsp_valid at accept+4.
REQ-039 Word 4 = 0x80F0017F; loads: byte 0x13 signed -> 0xFFFFFF80, byte 0x10 unsigned -> 0x0000007F, half 0x12 signed -> 0xFFFF80F0.
REQ-040 Half load at 0x11, word load at 0x12, size 11, word addr 4*DM_DEPTH -> rsp_err=1 at accept+1, rsp_rdata=0, no dm_read/dm_write.
REQ-041 rst asserted during RWAIT of a byte store -> no dm_write, no rsp_valid, req_ready=1 next cycle, memory word unchanged.
REQ-042 Back-to-back req_valid held high -> each accept only in IDLE, one rsp_valid per request, strobes never overlap.
